// File: rtl/mux_nway_rr_pkg.sv
// Shared definitions for the N-way registered mux.
// Mode encodings for the mode input.
package mux_nway_rr_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational rotating priority encoder.
// Scans req starting just after last, wrapping around.
module rr_arbiter_pick #(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  grant,
    output logic              found
);
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (int'(last) + k) % NUM_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = SEL_W'(idx);
            end
        end
    end
endmodule

// File: rtl/mux_nway_rr.sv
// N-channel registered stream mux with fixed-select
// and round-robin arbitration modes.
module mux_nway_rr
    import mux_nway_rr_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic [SEL_W-1:0] grant;
    logic             found;
    logic             fix_found;
    logic [WIDTH-1:0] grant_data;
    logic             can_accept;
    logic             accept;

    rr_arbiter_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req   (in_valid),
        .last  (last_grant),
        .grant (rr_grant),
        .found (rr_found)
    );

    // Out-of-range sel matches no channel, so it never transfers.
    always_comb begin
        fix_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) fix_found = in_valid[i];
        end
    end

    always_comb begin
        grant = sel;
        found = fix_found;
        if (mode == MODE_RR) begin
            grant = rr_grant;
            found = rr_found;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign can_accept = !out_valid || out_ready;
    assign accept     = can_accept && found && !reset;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = accept && (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= grant_data;
            out_ch     <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_nway_rr.sv
// Self-checking bench for mux_nway_rr: directed steps
// plus a randomized phase against a behavioural model.
module tb_mux_nway_rr;
    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode;
    logic [1:0]   sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_last;

    mux_nway_rr #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which channel the rules say wins this cycle, or -1.
    function automatic int model_pick();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            if (in_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        int g;
        logic can;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_pick();
        can = !m_valid || out_ready;
        exp_rdy = '0;
        if (can && g >= 0 && !reset) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N - 1;
        end else if (can && g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            m_last  = g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] d);
        in_data[c*W +: W] = d;
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_last = N - 1;
        reset = 1'b1; mode = 1'b0; sel = '0;
        in_data = '0; in_valid = '0; out_ready = 1'b1;
        #2;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;

        // Legacy fixed-select equivalence
        set_ch(0, 16'h0000); set_ch(1, 16'h5555);
        set_ch(2, 16'hAAAA); set_ch(3, 16'hFFFF);
        in_valid = 4'b1111;
        for (int s = 0; s < N; s++) begin
            sel = 2'(s);
            #1 chk("t1_ready", 32'(in_ready), 32'(1 << s));
            tick();
            chk("t1_ch", 32'(out_ch), 32'(s));
            chk("t1_data", 32'(out_data), 32'(16'h5555 * s));
        end

        // Round-robin fairness from reset
        reset = 1'b1;
        tick();
        reset = 1'b0; mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_ch", 32'(out_ch), 32'(i % N));
            chk("t2_valid", 32'(out_valid), 32'd1);
        end

        // Sparse round robin
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_alt", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_fix", 32'(out_ch), 32'd2);
        end

        // Back-pressure holds the word stable
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_data", 32'(out_data), 32'hAAAA);
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_ready", 32'(in_ready), 32'd0);
        end
        set_ch(2, 16'h1234);
        out_ready = 1'b1;
        #1 chk("t4_accept", 32'(in_ready), 32'b0100);
        tick();
        chk("t4_next", 32'(out_data), 32'h1234);

        // Reset mid-stream
        in_valid = 4'b1000;
        tick();
        chk("t5_pre", 32'(out_data), 32'hFFFF);
        reset = 1'b1;
        #1 chk("t5_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_data", 32'(out_data), 32'd0);
        chk("t5_ch", 32'(out_ch), 32'd0);
        reset = 1'b0; in_valid = 4'b1111;
        tick();
        chk("t5_first", 32'(out_ch), 32'd0);

        // Fixed mode, selected channel not valid
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
        tick();
        chk("t6_drain", 32'(out_valid), 32'd0);
        tick();
        chk("t6_idle", 32'(out_valid), 32'd0);
        in_valid = 4'b1111;
        tick();
        chk("t6_acc", 32'(out_valid), 32'd1);
        chk("t6_ch", 32'(out_ch), 32'd2);

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) set_ch(c, 16'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
